fp_add_arbiter: RTL

- Round-robin arbiter and sequencer that time-shares one combinational single-precision floating-point adder among NREQ requesters, e.g. the x/y/z update paths of the atanh CORDIC loop.
- Accepts one operand pair at a time over per-requester valid/ready channels and drives registered operands into the shared adder.
- Captures the adder result one cycle later and returns it on a single tagged response channel.
- The adder itself is instantiated outside this block; only its operand and result buses connect here.

---
 rtl/fp_add_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//   Round-robin arbiter/sequencer that time-shares one external combinational
//   single-precision adder among NREQ requesters. One operand pair is accepted
//   at a time, driven to the adder from registers, and the sum is captured one
//   cycle later and returned on a single tagged response channel.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : per-requester operand-pair valid
//   req_ready  : one-hot grant (combinational, IDLE only)
//   req_a/b    : packed operands, requester i at [32i+31:32i]
//   add_c/d    : registered operands to the shared adder
//   add_result : combinational sum from the shared adder
//   rsp_valid  : response holds a valid sum
//   rsp_ready  : consumer accepts the response
//   rsp_id     : owner of the response
//   rsp_data   : registered sum
//   busy       : state is not IDLE
//   ops_done   : completed-response counter, wraps modulo 2^16
module fp_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [31:0]          add_c,
  output logic [31:0]          add_d,
  input  logic [31:0]          add_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [31:0]     add_c_q, add_c_d;
  logic [31:0]     add_d_q, add_d_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     ops_done_q, ops_done_d;

  logic            found_s;
  logic [IDW-1:0]  winner_s;
  logic [NREQ-1:0] grant_s;

  // (base + off) mod NREQ for base < NREQ and off < NREQ, without a divider
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    sum = (sum >= 32'(NREQ)) ? (sum - 32'(NREQ)) : sum;
    return IDW'(sum);
  endfunction

  // Round-robin pick: scan from ptr upward; walking offsets downward lets the
  // smallest offset (closest to ptr) be the last and therefore winning write.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(ptr_q, 32'(k))]) begin
        found_s  = 1'b1;
        winner_s = wrap_add(ptr_q, 32'(k));
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  // Next-state and datapath-load logic for the IDLE/CALC/RESP sequencer
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_c_d     = add_c_q;
    add_d_d     = add_d_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    ops_done_d  = ops_done_q;
    grant_s     = '0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_s  = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
          add_c_d  = req_a[32*int'(winner_s) +: 32];
          add_d_d  = req_b[32*int'(winner_s) +: 32];
          rsp_id_d = winner_s;
          ptr_d    = wrap_add(winner_s, 32'd1);
          state_d  = ST_CALC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALC: begin
        rsp_data_d  = add_result;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 16'd1;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      add_c_q     <= 32'd0;
      add_d_q     <= 32'd0;
      rsp_data_q  <= 32'd0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      ops_done_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_c_q     <= add_c_d;
      add_d_q     <= add_d_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      ops_done_q  <= ops_done_d;
    end
  end

  // The grant is combinational, so it must be masked while reset is held
  assign req_ready = rst ? '0 : grant_s;
  assign add_c     = add_c_q;
  assign add_d     = add_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign ops_done  = ops_done_q;

endmodule
